shifter_pipe: RTL and testbench
===============================

# shifter_pipe

Pipelined, parametrised barrel shifter/rotator for the execute datapath. It generalises the fixed 16-bit rotate-left stage into a WIDTH-bit, log2(WIDTH)-stage unit with four operations. One shift stage is handled per cycle, and a valid/ready handshake supports backpressure. It sits between operand select and the ALU result mux. Results come back in order after a fixed latency of CNT_W cycles.

## Interface
- WIDTH, 16, data width; must equal 2**CNT_W.
- CNT_W, 4, shift-amount width and number of pipeline stages.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  unit accepts an operand this cycle.
- in_data  in  WIDTH  operand.
- in_cnt  in  CNT_W  shift amount, 0..WIDTH-1.
- in_op  in  2  operation select: 00 rotate left, 01 shift left logical, 10 shift right arithmetic, 11 shift right logical.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_zero  out  1  out_data == 0; qualified by out_valid.

## Operation
- There are CNT_W stages, S0..S(CNT_W-1). Each stage register holds: valid, data[WIDTH], op[2], and cnt[CNT_W].
- Stage k applies a shift/rotate of 2^k in the direction given by op, only if cnt[k]=1. Otherwise it passes the data through.
  - Stage 0 acts on in_data and in_cnt directly.
  - Stage k>0 acts on the S(k-1) register.
- Fill rules per op:
  - Rotate left: bits wrap from MSB to LSB.
  - Shift left logical: zero fill at the LSBs.
  - Shift right arithmetic: fill with bit WIDTH-1 of the stage input, so the sign is preserved across stages.
  - Shift right logical: zero fill at the MSBs.
- Global advance signal: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - When adv=1, every stage loads from its predecessor. S0 loads {in_valid, stage-0 result, in_op, in_cnt}.
  - When adv=0, every stage holds.
  - Bubbles are not collapsed.
- An input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- out_valid, out_data and out_zero come straight from S(CNT_W-1).
  - out_zero is computed from the stage-(CNT_W-1) result before it is registered. It is not an output-side reduction.
- Count 0 passes the operand unchanged for every op.
- When in_valid=0 and adv=1, S0 loads valid=0. Its data contents are don't-care but deterministic (load 0).
- There is no combinational path from in_valid or in_data to the outputs. The only combinational input-to-output path is out_ready → in_ready.

## Timing
- Reset, synchronous: all stage valid bits = 0 and all data/op/cnt registers = 0.
  - Outputs during and after reset: out_valid=0, out_data=0, out_zero=0, in_ready=1.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+CNT_W-1, i.e. on the cycle following the CNT_W-th capturing edge. That is 4 cycles for the default.
- Throughput: one result per cycle while out_ready=1.
- Backpressure:
  - While out_valid=1 and out_ready=0, the whole pipe freezes.
  - in_ready=0 during the freeze; in_data is ignored.
  - out_data is stable until the transfer completes.
- Simultaneous output transfer and input acceptance in the same cycle is allowed and loses no data.
- Reset mid-operation discards all in-flight operands. No result appears afterwards for operands accepted before reset.
- Ordering: results leave in exactly acceptance order.

## Test plan
- Reset, then idle: out_valid=0, out_data=0x0000, out_zero=0, in_ready=1 for 10 cycles.
- Directed ops, WIDTH=16, out_ready=1:
  - ROL 0x1234 cnt 4 → 0x2341.
  - SLL 0x8001 cnt 1 → 0x0002.
  - SRA 0x8000 cnt 15 → 0xFFFF.
  - SRL 0x8000 cnt 15 → 0x0001.
  - Each result arrives exactly 4 cycles after acceptance.
- Zero flag and count 0:
  - SLL 0x8000 cnt 1 → 0x0000, out_zero=1.
  - ROL 0xA5A5 cnt 0 → 0xA5A5, out_zero=0.
- Backpressure:
  - Hold out_ready=0 and stream 6 back-to-back operands.
  - in_ready drops to 0 once the first result reaches the output; the pipe stays frozen with outputs stable.
  - Release out_ready: all accepted operands emerge in order, one per cycle, none lost or duplicated.
- Reset mid-stream:
  - Accept 3 operands, assert rst for 1 cycle on the next cycle.
  - out_valid stays 0 for the following 8 cycles; a new operand after reset completes normally with 4-cycle latency.
- Random regression: 10,000 random op/cnt/data values with random out_ready, compared against a behavioural model. Also run at WIDTH=32, CNT_W=5 and WIDTH=8, CNT_W=3.

Source files
------------

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter/rotator: one power-of-two shift stage per cycle,
// valid/ready handshake with whole-pipe freeze under backpressure.
module shifter_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic [CNT_W-1:0] i_in_cnt,
  input  logic [1:0]       i_in_op,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_zero
);

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic             r_valid [CNT_W];
  logic [WIDTH-1:0] r_data  [CNT_W];
  logic [1:0]       r_op    [CNT_W];
  logic [CNT_W-1:0] r_cnt   [CNT_W];
  logic             r_zero;

  logic             w_adv;
  logic             w_valid_in [CNT_W];
  logic [WIDTH-1:0] w_data_in  [CNT_W];
  logic [1:0]       w_op_in    [CNT_W];
  logic [CNT_W-1:0] w_cnt_in   [CNT_W];
  logic [WIDTH-1:0] w_res      [CNT_W];

  assign w_adv       = ~o_out_valid | i_out_ready;
  assign o_in_ready  = w_adv;
  assign o_out_valid = r_valid[CNT_W-1];
  assign o_out_data  = r_data[CNT_W-1];
  assign o_out_zero  = r_zero;

  for (genvar k = 0; k < CNT_W; k++) begin : g_stage
    localparam int SH = 1 << k;
    logic [WIDTH-1:0] w_rol, w_sll, w_sra, w_srl;

    if (k == 0) begin : g_first
      assign w_valid_in[k] = i_in_valid;
      assign w_data_in[k]  = i_in_data;
      assign w_op_in[k]    = i_in_op;
      assign w_cnt_in[k]   = i_in_cnt;
    end else begin : g_next
      assign w_valid_in[k] = r_valid[k-1];
      assign w_data_in[k]  = r_data[k-1];
      assign w_op_in[k]    = r_op[k-1];
      assign w_cnt_in[k]   = r_cnt[k-1];
    end

    // SRA fills from the stage input MSB, so sign survives every stage
    assign w_rol = {w_data_in[k][WIDTH-SH-1:0], w_data_in[k][WIDTH-1:WIDTH-SH]};
    assign w_sll = {w_data_in[k][WIDTH-SH-1:0], {SH{1'b0}}};
    assign w_sra = {{SH{w_data_in[k][WIDTH-1]}}, w_data_in[k][WIDTH-1:SH]};
    assign w_srl = {{SH{1'b0}}, w_data_in[k][WIDTH-1:SH]};

    assign w_res[k] = !w_cnt_in[k][k]        ? w_data_in[k] :
                      (w_op_in[k] == OP_ROL) ? w_rol :
                      (w_op_in[k] == OP_SLL) ? w_sll :
                      (w_op_in[k] == OP_SRA) ? w_sra : w_srl;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < CNT_W; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_op[k]    <= '0;
        r_cnt[k]   <= '0;
      end
      r_zero <= 1'b0;
    end else if (w_adv) begin
      // bubbles carry all-zero contents so idle outputs stay deterministic
      r_valid[0] <= i_in_valid;
      r_data[0]  <= i_in_valid ? w_res[0] : '0;
      r_op[0]    <= i_in_valid ? i_in_op  : '0;
      r_cnt[0]   <= i_in_valid ? i_in_cnt : '0;
      for (int k = 1; k < CNT_W; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_data[k]  <= w_res[k];
        r_op[k]    <= r_op[k-1];
        r_cnt[k]   <= r_cnt[k-1];
      end
      r_zero <= w_valid_in[CNT_W-1] && (w_res[CNT_W-1] == '0);
    end
  end

endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe: directed ops, backpressure, mid-stream reset and a
// random regression against a queue-based timing/result model.
module tb_shifter_pipe;
  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          i_rst, i_in_valid, i_out_ready;
  logic [W-1:0]  i_in_data;
  logic [CW-1:0] i_in_cnt;
  logic [1:0]    i_in_op;
  logic          o_in_ready, o_out_valid, o_out_zero;
  logic [W-1:0]  o_out_data;

  shifter_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_data(i_in_data), .i_in_cnt(i_in_cnt), .i_in_op(i_in_op),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data), .o_out_zero(o_out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    int           e;
    int           f;
  } ent_t;

  ent_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           edges  = 0;
  int           frz    = 0;
  bit           was_frozen = 0;
  bit           idle_chk   = 0;
  logic [W-1:0] held;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] d, input int c, input logic [1:0] op);
    longint unsigned x, m, r;
    x = 64'(d);
    m = (64'd1 << W) - 1;
    case (op)
      2'b00:   r = ((x << c) | (x >> (W - c))) & m;
      2'b01:   r = (x << c) & m;
      2'b10:   r = (x >> c) | (d[W-1] ? (m & ~(m >> c)) : 64'd0);
      default: r = x >> c;
    endcase
    return r[W-1:0];
  endfunction

  // One clock: drive, check at negedge, commit model at posedge.
  task automatic cycle(input logic rst, input logic v, input logic [W-1:0] d,
                       input logic [CW-1:0] c, input logic [1:0] op, input logic ordy,
                       input logic [W-1:0] exp, output bit acc);
    bit ev, adv;
    i_rst = rst; i_in_valid = v; i_in_data = d; i_in_cnt = c; i_in_op = op;
    i_out_ready = ordy;
    @(negedge clk);
    ev = (q.size() > 0) && ((edges - q[0].e - (frz - q[0].f)) >= CW - 1);
    adv = !ev || ordy;
    chk("out_valid", 64'(o_out_valid), 64'(ev));
    chk("in_ready", 64'(o_in_ready), 64'(adv));
    if (ev) begin
      chk("out_data", 64'(o_out_data), 64'(q[0].r));
      chk("out_zero", 64'(o_out_zero), 64'(q[0].r == '0));
    end
    if (idle_chk) begin
      chk("idle_data", 64'(o_out_data), 64'd0);
      chk("idle_zero", 64'(o_out_zero), 64'd0);
    end
    if (was_frozen) chk("frozen_stable", 64'(o_out_data), 64'(held));
    was_frozen = ev && !ordy;
    held = o_out_data;
    @(posedge clk);
    edges++;
    acc = 0;
    if (rst) begin
      q.delete();
      was_frozen = 0;
    end else begin
      if (!adv) frz++;
      if (ev && ordy) void'(q.pop_front());
      if (v && adv) begin
        q.push_back('{exp, edges, frz});
        acc = 1;
      end
    end
    #1;
  endtask

  initial begin
    bit           a;
    int           nacc;
    logic [W-1:0] d;
    logic [CW-1:0] c;
    logic [1:0]   op;

    i_rst = 1'b1; i_in_valid = 0; i_in_data = '0; i_in_cnt = '0; i_in_op = '0;
    i_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    idle_chk = 1;
    repeat (10) cycle(0, 0, '0, '0, 2'b00, 1, '0, a);
    idle_chk = 0;

    cycle(0, 1, 16'h1234, 4'd4,  2'b00, 1, 16'h2341, a);
    cycle(0, 1, 16'h8001, 4'd1,  2'b01, 1, 16'h0002, a);
    cycle(0, 1, 16'h8000, 4'd15, 2'b10, 1, 16'hFFFF, a);
    cycle(0, 1, 16'h8000, 4'd15, 2'b11, 1, 16'h0001, a);
    cycle(0, 1, 16'h8000, 4'd1,  2'b01, 1, 16'h0000, a);
    cycle(0, 1, 16'hA5A5, 4'd0,  2'b00, 1, 16'hA5A5, a);
    repeat (6) cycle(0, 0, '0, '0, 2'b00, 1, '0, a);
    chk("directed_drained", 64'(q.size()), 64'd0);

    // backpressure: offer 6 operands with the consumer stalled, then release
    nacc = 0;
    for (int i = 0; i < 40 && nacc < 6; i++) begin
      d = W'($urandom); c = CW'($urandom); op = 2'($urandom);
      cycle(0, 1, d, c, op, (i >= 12), ref_op(d, int'(c), op), a);
      while (!a && nacc < 6 && i < 40) begin
        i++;
        cycle(0, 1, d, c, op, (i >= 12), ref_op(d, int'(c), op), a);
      end
      if (a) nacc++;
    end
    chk("bp_accepted", 64'(nacc), 64'd6);
    repeat (8) cycle(0, 0, '0, '0, 2'b00, 1, '0, a);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // reset mid-stream
    for (int i = 0; i < 3; i++) begin
      d = W'($urandom); c = CW'($urandom); op = 2'($urandom);
      cycle(0, 1, d, c, op, 1, ref_op(d, int'(c), op), a);
    end
    cycle(1, 0, '0, '0, 2'b00, 1, '0, a);
    repeat (8) cycle(0, 0, '0, '0, 2'b00, 1, '0, a);
    cycle(0, 1, 16'h00F0, 4'd3, 2'b11, 1, 16'h001E, a);
    repeat (5) cycle(0, 0, '0, '0, 2'b00, 1, '0, a);
    chk("rst_drained", 64'(q.size()), 64'd0);

    for (int i = 0; i < 10000; i++) begin
      d = W'($urandom); c = CW'($urandom); op = 2'($urandom);
      cycle(0, ($urandom_range(0, 3) != 0), d, c, op, ($urandom_range(0, 3) != 0),
            ref_op(d, int'(c), op), a);
    end
    repeat (12) cycle(0, 0, '0, '0, 2'b00, 1, '0, a);
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
